mdu_sched: RTL

MDU_SCHED -- requirements
Module: mdu_sched

---
 rtl/mdu_sched_pkg.sv | 31 +++
 rtl/mdu_sched_calc.sv | 30 +++
 rtl/mdu_sched.sv | 79 +++++++
 3 files changed

// File: rtl/mdu_sched_pkg.sv
// mdu_sched_pkg: shared MDU op encodings, default latencies and the operand bus.
package mdu_sched_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] rs;
        logic [31:0] rt;
    } md_req_t;

    function automatic logic is_div(input op_e op);
        return op == OP_DIV || op == OP_DIVU;
    endfunction

    function automatic logic is_multi(input op_e op);
        return op == OP_MULT || op == OP_MULTU || is_div(op);
    endfunction

endpackage

// File: rtl/mdu_sched_calc.sv
// mdu_calc: combinational multiply/divide datapath producing {hi,lo}.
module mdu_calc
    import mdu_sched_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o
);
    logic signed [63:0] sa, sm, sd, sq, sr;
    logic [31:0] bd, uq, ur;
    logic [63:0] up;
    always_comb begin
        // Zero divisor is replaced by 1 so the datapath never produces X.
        bd = (b_i == '0) ? 32'd1 : b_i;
        // 64-bit signed division keeps 0x80000000 / -1 well defined.
        sa = {{32{a_i[31]}}, a_i};
        sm = {{32{b_i[31]}}, b_i};
        sd = {{32{bd[31]}}, bd};
        sq = sa / sd;
        sr = sa % sd;
        uq = a_i / bd;
        ur = a_i % bd;
        up = {32'd0, a_i} * {32'd0, b_i};
        res_o = (op_e'(op_i) == OP_MULT)  ? sa * sm :
                (op_e'(op_i) == OP_MULTU) ? up :
                (op_e'(op_i) == OP_DIV)   ? {sr[31:0], sq[31:0]} :
                (op_e'(op_i) == OP_DIVU)  ? {ur, uq} : 64'd0;
    end
endmodule

// File: rtl/mdu_sched.sv
// mdu_sched: multi-cycle MDU scheduler with HI/LO registers and pipeline stall request.
// Define MDU_DIV0_GUARD_EN to keep HI/LO unchanged on a divide by zero.
module mdu_sched
    import mdu_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    md_req_t       req_q, req_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   res;
    logic          launch, done, mt, wr;

    mdu_calc u_calc (
        .op_i  (req_q.op),
        .a_i   (req_q.rs),
        .b_i   (req_q.rt),
        .res_o (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        launch = state_q == IDLE && start && is_multi(op_e'(op));
        mt     = state_q == IDLE && start;
        done   = state_q == RUN && cnt_q == CW'(1);
`ifdef MDU_DIV0_GUARD_EN
        wr = !(is_div(req_q.op) && req_q.rt == '0);
`else
        wr = 1'b1;
`endif
        state_d = launch ? RUN : done ? IDLE : state_q;
        cnt_d   = launch ? (is_div(op_e'(op)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
                  (state_q == RUN) ? cnt_q - CW'(1) : cnt_q;
        req_d   = launch ? '{op: op_e'(op), rs: rs_val, rt: rt_val} : req_q;
        hi_d    = (done && wr) ? res[63:32] : (mt && op_e'(op) == OP_MTHI) ? rs_val : hi_q;
        lo_d    = (done && wr) ? res[31:0]  : (mt && op_e'(op) == OP_MTLO) ? rs_val : lo_q;
    end

    always_comb begin
        busy      = state_q == RUN;
        stall_req = d_is_md & (busy | (start & is_multi(op_e'(op))));
        hi        = hi_q;
        lo        = lo_q;
    end
endmodule
